controle_deslocamento: RTL and testbench

//  Mode sequencer and bidirectional shift register on the far side of the 3:1 mode mux.
//  - Turns user mode buttons into the select code (ch1,ch0) that drives the mux.
//  - Consumes the mux's serial output (entrada_serial): parallel-loads, shifts or holds an LED register.
//  - Sits between the debounced button block and the LED display.

---
 rtl/controle_deslocamento.sv | 150 +++++++++++++++
 tb/tb_controle_deslocamento.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_deslocamento.sv
// Mode sequencer and bidirectional LED shift register behind the 3:1 mode mux.
// Latency: a shift lands DIV_PASSO edges after the press; a load lands 1 edge after DEFINIR.
// No backpressure: buttons are edge-detected and acted on at once; optional CONTADOR_PASSOS_EN adds num_passos.
module controle_deslocamento #(
   parameter int LARGURA   = 8,
   parameter int DIV_PASSO = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               botao_definir,
   input  logic               botao_esq_dir,
   input  logic               botao_dir_esq,
   input  logic               botao_parar,
   input  logic [LARGURA-1:0] valores_in,
   input  logic               entrada_serial,
   output logic               ch0,
   output logic               ch1,
   output logic [LARGURA-1:0] saida,
   output logic               passo
`ifdef CONTADOR_PASSOS_EN
   ,
   output logic [7:0]         num_passos
`endif
);

   localparam int              CW      = $clog2(DIV_PASSO);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DIV_PASSO - 1);

   // Button bit positions, highest priority first.
   localparam int B_PAR = 3;
   localparam int B_DEF = 2;
   localparam int B_ESQ = 1;
   localparam int B_DIR = 0;

   // Encoding equals {ch1,ch0}, so the mux select comes straight from flops.
   typedef enum logic [1:0] {
      DEFINIR = 2'b00,
      ESQ_DIR = 2'b01,
      DIR_ESQ = 2'b10,
      PARADO  = 2'b11
   } estado_t;

   estado_t            estado_q, estado_d;
   logic [3:0]         botoes_q;
   logic [3:0]         botoes_agora;
   logic [3:0]         borda;
   logic [CW-1:0]      cont_q, cont_d;
   logic [LARGURA-1:0] saida_q, saida_d;
   logic               passo_q, passo_d;
   logic               carga;
   logic               desloca;
`ifdef CONTADOR_PASSOS_EN
   logic [7:0]         num_q, num_d;
`endif

   assign botoes_agora = {botao_parar, botao_definir, botao_esq_dir, botao_dir_esq};
   assign borda        = botoes_agora & ~botoes_q;

   // State register, button history and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q <= PARADO;
         botoes_q <= '0;
         cont_q   <= '0;
         saida_q  <= '0;
         passo_q  <= 1'b0;
`ifdef CONTADOR_PASSOS_EN
         num_q    <= '0;
`endif
      end else begin
         estado_q <= estado_d;
         botoes_q <= botoes_agora;
         cont_q   <= cont_d;
         saida_q  <= saida_d;
         passo_q  <= passo_d;
`ifdef CONTADOR_PASSOS_EN
         num_q    <= num_d;
`endif
      end
   end

   // Next state, step counter and shift/load decisions; a button action on a step edge suppresses the shift.
   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      saida_d  = saida_q;
      passo_d  = 1'b0;
      carga    = 1'b0;
      desloca  = 1'b0;
      case (estado_q)
         PARADO: begin
            cont_d = '0;
            if (borda[B_PAR])      estado_d = PARADO;
            else if (borda[B_DEF]) estado_d = DEFINIR;
            else if (borda[B_ESQ]) estado_d = ESQ_DIR;
            else if (borda[B_DIR]) estado_d = DIR_ESQ;
         end
         DEFINIR: begin
            carga    = 1'b1;
            saida_d  = valores_in;
            cont_d   = '0;
            estado_d = PARADO;
         end
         ESQ_DIR, DIR_ESQ: begin
            if (borda[B_PAR]) begin
               estado_d = PARADO;
               cont_d   = '0;
            end else if (borda[B_DEF]) begin
               estado_d = DEFINIR;
               cont_d   = '0;
            end else if (estado_q == ESQ_DIR && borda[B_DIR] && !borda[B_ESQ]) begin
               estado_d = DIR_ESQ;
               cont_d   = '0;
            end else if (estado_q == DIR_ESQ && borda[B_ESQ]) begin
               estado_d = ESQ_DIR;
               cont_d   = '0;
            end else if (cont_q == CNT_MAX) begin
               desloca = 1'b1;
               passo_d = 1'b1;
               cont_d  = '0;
               if (estado_q == ESQ_DIR)
                  saida_d = {entrada_serial, saida_q[LARGURA-1:1]};
               else
                  saida_d = {saida_q[LARGURA-2:0], entrada_serial};
            end else begin
               cont_d = cont_q + CW'(1);
            end
         end
         default: estado_d = PARADO;
      endcase
   end

`ifdef CONTADOR_PASSOS_EN
   // Shift counter: cleared by a load, wraps naturally at 8 bits.
   always_comb begin
      num_d = num_q;
      if (carga)
         num_d = '0;
      else if (desloca)
         num_d = num_q + 8'd1;
   end

   assign num_passos = num_q;
`endif

   assign {ch1, ch0} = estado_q;
   assign saida      = saida_q;
   assign passo      = passo_q;

endmodule

// File: tb/tb_controle_deslocamento.sv
module tb_controle_deslocamento;
   localparam int L = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         b_def = 1'b0, b_ed = 1'b0, b_de = 1'b0, b_par = 1'b0;
   logic         ser = 1'b0;
   logic [L-1:0] val = '0;
   logic         ch0, ch1, passo;
   logic [L-1:0] saida;
`ifdef CONTADOR_PASSOS_EN
   logic [7:0]   num_passos;
`endif

   always #5 clk = ~clk;

   controle_deslocamento #(.LARGURA(L), .DIV_PASSO(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .botao_definir(b_def), .botao_esq_dir(b_ed),
      .botao_dir_esq(b_de), .botao_parar(b_par),
      .valores_in(val), .entrada_serial(ser),
      .ch0(ch0), .ch1(ch1), .saida(saida), .passo(passo)
`ifdef CONTADOR_PASSOS_EN
      , .num_passos(num_passos)
`endif
   );

   int checks = 0;
   int erros  = 0;

   // Behavioural reference: a mode plus a countdown of edges to the next step.
   typedef enum {M_PARADO, M_DEFINIR, M_ESQ, M_DIR} modo_t;
   modo_t        m_modo = M_PARADO;
   int           m_rest = D;
   logic [L-1:0] m_saida = '0;
   logic         m_passo = 1'b0;
   bit   [3:0]   m_hist = '0;
   int           m_num = 0;

   function automatic logic [1:0] ch_de(modo_t m);
      case (m)
         M_PARADO: return 2'b11;
         M_DEFINIR: return 2'b00;
         M_ESQ: return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   task automatic modelo();
      bit [3:0] agora;
      bit [3:0] borda;
      agora = {b_par, b_def, b_ed, b_de};
      borda = agora & ~m_hist;
      m_hist = agora;
      m_passo = 1'b0;
      if (!rst_n) begin
         m_modo = M_PARADO; m_saida = '0; m_rest = D; m_hist = '0; m_num = 0;
         return;
      end
      case (m_modo)
         M_DEFINIR: begin
            m_saida = val; m_num = 0; m_modo = M_PARADO;
         end
         M_PARADO: begin
            if (borda[3]) m_modo = M_PARADO;
            else if (borda[2]) m_modo = M_DEFINIR;
            else if (borda[1]) begin m_modo = M_ESQ; m_rest = D; end
            else if (borda[0]) begin m_modo = M_DIR; m_rest = D; end
         end
         default: begin
            if (borda[3]) m_modo = M_PARADO;
            else if (borda[2]) m_modo = M_DEFINIR;
            else if (m_modo == M_ESQ && borda[0] && !borda[1]) begin m_modo = M_DIR; m_rest = D; end
            else if (m_modo == M_DIR && borda[1]) begin m_modo = M_ESQ; m_rest = D; end
            else begin
               m_rest--;
               if (m_rest == 0) begin
                  if (m_modo == M_ESQ) m_saida = (m_saida >> 1) | (L'(ser) << (L - 1));
                  else                 m_saida = (m_saida << 1) | L'(ser);
                  m_rest = D;
                  m_passo = 1'b1;
                  m_num = (m_num + 1) % 256;
               end
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         erros++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge: advance the model, then compare 1 time unit after the edge.
   task automatic ciclo();
      @(posedge clk);
      modelo();
      #1;
      chk("saida_model", saida, m_saida);
      chk("ch_model", {ch1, ch0}, ch_de(m_modo));
      chk("passo_model", passo, m_passo);
`ifdef CONTADOR_PASSOS_EN
      chk("num_model", num_passos, m_num[7:0]);
`endif
   endtask

   task automatic carregar(input logic [L-1:0] v);
      val = v; b_def = 1'b1; ciclo(); b_def = 1'b0; ciclo();
   endtask

   initial begin
      logic [L-1:0] esperado [3];
      int defs;

      // 1: reset, then reset again in the middle of a shift
      repeat (2) ciclo();
      rst_n = 1'b1; ciclo();
      b_ed = 1'b1; ciclo(); b_ed = 1'b0; repeat (2) ciclo();
      rst_n = 1'b0; repeat (2) ciclo();
      chk("t1_rst_saida", saida, 8'h00);
      chk("t1_rst_ch", {ch1, ch0}, 2'b11);
      chk("t1_rst_passo", passo, 1'b0);
      rst_n = 1'b1; repeat (3) ciclo();
      chk("t1_hold_saida", saida, 8'h00);
      chk("t1_hold_ch", {ch1, ch0}, 2'b11);

      // 2: load A5, DEFINIR lasts exactly one cycle
      val = 8'hA5; b_def = 1'b1; ciclo(); b_def = 1'b0;
      chk("t2_ch_definir", {ch1, ch0}, 2'b00);
      ciclo();
      chk("t2_saida_A5", saida, 8'hA5);
      chk("t2_ch_parado", {ch1, ch0}, 2'b11);

      // 3: shift left-to-right with serial 1
      ser = 1'b1; b_ed = 1'b1; ciclo(); b_ed = 1'b0;
      chk("t3_ch_esq", {ch1, ch0}, 2'b01);
      esperado[0] = 8'hD2; esperado[1] = 8'hE9; esperado[2] = 8'hF4;
      for (int k = 0; k < 3; k++) begin
         repeat (D - 1) ciclo();
         chk("t3_pre_passo", passo, 1'b0);
         ciclo();
         chk("t3_saida", saida, 32'(esperado[k]));
         chk("t3_passo", passo, 1'b1);
      end
      b_par = 1'b1; ciclo(); b_par = 1'b0; ciclo();
      chk("t3_parado", {ch1, ch0}, 2'b11);

      // 4: shift right-to-left with serial 0, then reverse mid-count
      carregar(8'hA5);
      ser = 1'b0; b_de = 1'b1; ciclo(); b_de = 1'b0;
      chk("t4_ch_dir", {ch1, ch0}, 2'b10);
      esperado[0] = 8'h4A; esperado[1] = 8'h94;
      for (int k = 0; k < 2; k++) begin
         repeat (D) ciclo();
         chk("t4_saida", saida, 32'(esperado[k]));
      end
      ciclo();
      b_ed = 1'b1; ciclo(); b_ed = 1'b0;
      chk("t4_troca_sem_passo", saida, 8'h94);
      repeat (D - 1) ciclo();
      chk("t4_ainda_94", saida, 8'h94);
      ciclo();
      chk("t4_passo_reinicia", saida, 8'h4A);

      // 5: simultaneous parar+esq_dir; held buttons act once
      b_par = 1'b1; ciclo(); b_par = 1'b0; ciclo();
      b_par = 1'b1; b_ed = 1'b1; repeat (20) ciclo();
      chk("t5_ch_parado", {ch1, ch0}, 2'b11);
      chk("t5_saida_igual", saida, 8'h4A);
      b_par = 1'b0; b_ed = 1'b0; ciclo();
      val = 8'h3C; b_def = 1'b1; defs = 0;
      for (int k = 0; k < 20; k++) begin
         ciclo();
         if ({ch1, ch0} == 2'b00) defs++;
      end
      b_def = 1'b0; ciclo();
      chk("t5_definir_uma_vez", defs, 1);
      chk("t5_saida_3C", saida, 8'h3C);

`ifdef CONTADOR_PASSOS_EN
      // 6: shift counter, clear on load, wrap
      b_ed = 1'b1; ciclo(); b_ed = 1'b0;
      repeat (3 * D) ciclo();
      chk("t6_num3", num_passos, 8'd3);
      b_def = 1'b1; ciclo(); b_def = 1'b0; ciclo();
      chk("t6_num0", num_passos, 8'd0);
      b_ed = 1'b1; ciclo(); b_ed = 1'b0;
      repeat (260 * D) ciclo();
      chk("t6_num_wrap", num_passos, 8'd4);
      b_par = 1'b1; ciclo(); b_par = 1'b0; ciclo();
`endif

      // Random phase against the reference model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) b_ed  = ~b_ed;
         if ($urandom_range(0, 5) == 0) b_de  = ~b_de;
         if ($urandom_range(0, 11) == 0) b_def = ~b_def;
         if ($urandom_range(0, 15) == 0) b_par = ~b_par;
         ser   = 1'($urandom);
         val   = L'($urandom);
         rst_n = ($urandom_range(0, 199) != 0);
         ciclo();
      end

      $display("CHECKS %0d ERRORS %0d", checks, erros);
      $finish;
   end
endmodule
